alu_seq_unit: RTL and testbench

- Parametrised, clocked successor to the combinational 3-operand logic unit with its 6-way result mux.
- Accepts operands a, b, c and an op select through a valid/ready handshake, then returns a registered 2W-bit result through a second valid/ready handshake.
- Single-cycle ops complete in one clock. Multiply runs on an internal shift-add engine for W cycles.
- Sits between operand-source logic and result consumers in the datapath.

---
 rtl/alu_seq_pkg.sv | 18 +
 rtl/alu_seq_unit_seq_mul.sv | 58 +++++
 rtl/alu_seq_unit.sv | 138 +++++++++++++
 tb/tb_alu_seq_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential three-operand ALU: op codes and FSM states.
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD3  = 3'd0;
    localparam logic [2:0] OP_MUL   = 3'd1;
    localparam logic [2:0] OP_ANDOR = 3'd2;
    localparam logic [2:0] OP_XOR3  = 3'd3;
    localparam logic [2:0] OP_SUB   = 3'd4;
    localparam logic [2:0] OP_CAT   = 3'd5;
    localparam logic [2:0] OP_MAC   = 3'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_unit_seq_mul.sv
// Shift-add multiplier: loads on start, then adds one multiplier bit per cycle
// (LSB first) for exactly W cycles. done/p are valid in the last busy cycle so
// the owner can register the product on that same edge.
module seq_mul #(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [2*W-1:0]   acc_init,
    output logic             done,
    output logic [2*W-1:0]   p
);
    localparam int CW = $clog2(W) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

    logic [2*W-1:0] mcand_r;
    logic [W-1:0]   mplier_r;
    logic [2*W-1:0] acc_r;
    logic [CW-1:0]  cnt_r;
    logic           busy_r;
    logic [2*W-1:0] addend_s;
    logic [2*W-1:0] acc_nx_s;

    // Next accumulator value and completion decode for the current step.
    always_comb begin
        addend_s = mplier_r[0] ? mcand_r : '0;
        acc_nx_s = acc_r + addend_s;
        done     = busy_r && (cnt_r == LAST_CNT);
        p        = acc_nx_s;
    end

    // Operand load on start, then one shift-add step per busy cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_r  <= '0;
            mplier_r <= '0;
            acc_r    <= '0;
            cnt_r    <= '0;
            busy_r   <= 1'b0;
        end else if (start) begin
            mcand_r  <= {{W{1'b0}}, a};
            mplier_r <= b;
            acc_r    <= acc_init;
            cnt_r    <= '0;
            busy_r   <= 1'b1;
        end else if (busy_r) begin
            acc_r    <= acc_nx_s;
            mcand_r  <= {mcand_r[2*W-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[W-1:1]};
            cnt_r    <= cnt_r + CW'(1);
            busy_r   <= (cnt_r != LAST_CNT);
        end
    end

endmodule

// File: rtl/alu_seq_unit.sv
// Sequential three-operand ALU with valid/ready on both sides.
// Single-cycle ops are registered on the accept edge; multiply uses seq_mul.
// Optional macro ALU_SEQ_MAC_EN turns op 6 into a*b+c (accumulator preload);
// without it op 6 is reported as illegal.
module alu_seq_unit
    import alu_seq_pkg::*;
#(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [W-1:0]     c,
    input  logic [2:0]       s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   z,
    output logic             err
);
    state_t         state_r;
    state_t         state_nx_s;
    logic [2*W-1:0] z_r;
    logic           err_r;
    logic           accept_s;
    logic           is_mul_s;
    logic [W+1:0]   sum_s;
    logic [2*W-1:0] res_s;
    logic           ill_s;
    logic [2*W-1:0] acc_init_s;
    logic           mul_done_s;
    logic [2*W-1:0] mul_p_s;

    assign accept_s  = in_valid && (state_r == IDLE);
    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);
    assign z         = z_r;
    assign err       = err_r;

    // Classify the select as multi-cycle and pick the accumulator preload.
    always_comb begin
`ifdef ALU_SEQ_MAC_EN
        is_mul_s   = (s == OP_MUL) || (s == OP_MAC);
        acc_init_s = (s == OP_MAC) ? {{W{1'b0}}, c} : '0;
`else
        is_mul_s   = (s == OP_MUL);
        acc_init_s = '0;
`endif
    end

    // Single-cycle op results, zero-extended to 2W; illegal selects flag err.
    always_comb begin
        sum_s = {2'b00, a} + {2'b00, b} + {2'b00, c};
        res_s = '0;
        ill_s = 1'b0;
        case (s)
            OP_ADD3:  res_s[W+1:0] = sum_s;
            OP_MUL:   res_s        = '0;
`ifdef ALU_SEQ_MAC_EN
            OP_MAC:   res_s        = '0;
`endif
            OP_ANDOR: res_s[W-1:0] = (a & b) | c;
            OP_XOR3:  res_s[W-1:0] = a ^ b ^ c;
            OP_SUB:   res_s[W-1:0] = a - b;
            OP_CAT:   res_s        = {a, b};
            default: begin
                res_s = '0;
                ill_s = 1'b1;
            end
        endcase
    end

    seq_mul #(.W(W)) u_mul (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (accept_s && is_mul_s),
        .a        (a),
        .b        (b),
        .acc_init (acc_init_s),
        .done     (mul_done_s),
        .p        (mul_p_s)
    );

    // Transaction FSM next-state decode.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nx_s = is_mul_s ? BUSY : DONE;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            BUSY: begin
                if (mul_done_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = BUSY;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Result and error registers; written only when a transaction completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_r   <= '0;
            err_r <= 1'b0;
        end else if (accept_s && !is_mul_s) begin
            z_r   <= res_s;
            err_r <= ill_s;
        end else if ((state_r == BUSY) && mul_done_s) begin
            z_r   <= mul_p_s;
            err_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit (W=8) with a result scoreboard.
module tb_alu_seq_unit;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b1;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic [W-1:0]   c = '0;
    logic [2:0]     s = 3'd0;
    logic           in_ready;
    logic           out_valid;
    logic [2*W-1:0] z;
    logic           err;

    int n_vec = 0;
    int n_miss = 0;
    logic [2*W:0] exp_q[$];

    always #5 clk = ~clk;

    alu_seq_unit #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .s         (s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .err       (err)
    );

    function automatic logic [2*W:0] model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                           input logic [W-1:0] tc, input logic [2:0] ts);
        int ia, ib, ic, r;
        logic e;
        ia = int'(ta); ib = int'(tb); ic = int'(tc);
        r = 0; e = 1'b0;
        case (ts)
            3'd0: r = ia + ib + ic;
            3'd1: r = ia * ib;
            3'd2: r = (ia & ib) | ic;
            3'd3: r = ia ^ ib ^ ic;
            3'd4: r = (ia - ib + (1 << W)) % (1 << W);
            3'd5: r = ia * (1 << W) + ib;
`ifdef ALU_SEQ_MAC_EN
            3'd6: r = ia * ib + ic;
`endif
            default: begin r = 0; e = 1'b1; end
        endcase
        return {e, r[2*W-1:0]};
    endfunction

    function automatic int exp_lat(input logic [2:0] ts);
`ifdef ALU_SEQ_MAC_EN
        if (ts == 3'd6) return W + 1;
`endif
        return (ts == 3'd1) ? W + 1 : 1;
    endfunction

    // Present an operand set and hold it until accepted; push expected result.
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic [W-1:0] tc, input logic [2:0] ts);
        int n;
        n = 0;
        a = ta; b = tb; c = tc; s = ts; in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_q.push_back(model(ta, tb, tc, ts));
    endtask

    // Wait (bounded) for out_valid; report latency and in_ready-high samples.
    task automatic wait_out(output int lat, output int ir_hi);
        lat = 1; ir_hi = 0;
        while (!out_valid && lat < 40) begin
            if (in_ready) ir_hi++;
            @(posedge clk); #1; lat++;
        end
        if (in_ready) ir_hi++;
    endtask

    task automatic test_reset();
        #12;
        n_vec++; if (in_ready !== 1'b1) begin n_miss++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        n_vec++; if (z !== 16'd0) begin n_miss++; $display("FAIL reset_z: got %0d want 0", z); end
        n_vec++; if (err !== 1'b0) begin n_miss++; $display("FAIL reset_err: got %0b want 0", err); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add3();
        int lat, irh;
        logic [2*W:0] e;
        out_ready = 1'b1;
        send(8'd200, 8'd100, 8'd50, 3'd0);
        wait_out(lat, irh);
        n_vec++; if (lat !== 1) begin n_miss++; $display("FAIL add3_latency: got %0d want 1", lat); end
        e = exp_q.pop_front();
        n_vec++; if ({err, z} !== e) begin n_miss++; $display("FAIL add3_result: got err=%0b z=%0d want err=%0b z=%0d", err, z, e[2*W], e[2*W-1:0]); end
        n_vec++; if (z !== 16'd350) begin n_miss++; $display("FAIL add3_value: got %0d want 350", z); end
        @(posedge clk); #1;
        n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_miss++; $display("FAIL add3_idle: got in_ready=%0b out_valid=%0b want 1/0", in_ready, out_valid); end
        // max operands: 3*(2^W-1)
        send(8'hFF, 8'hFF, 8'hFF, 3'd0);
        wait_out(lat, irh);
        e = exp_q.pop_front();
        n_vec++; if ({err, z} !== e) begin n_miss++; $display("FAIL add3_max: got err=%0b z=%0d want err=%0b z=%0d", err, z, e[2*W], e[2*W-1:0]); end
        @(posedge clk); #1;
    endtask

    task automatic test_mul();
        int lat, irh;
        logic [2*W:0] e;
        send(8'd255, 8'd255, 8'd0, 3'd1);
        wait_out(lat, irh);
        n_vec++; if (lat !== W + 1) begin n_miss++; $display("FAIL mul_latency: got %0d want %0d", lat, W + 1); end
        n_vec++; if (irh !== 0) begin n_miss++; $display("FAIL mul_in_ready_low: got %0d high samples want 0", irh); end
        e = exp_q.pop_front();
        n_vec++; if ({err, z} !== e) begin n_miss++; $display("FAIL mul_result: got err=%0b z=%0d want err=%0b z=%0d", err, z, e[2*W], e[2*W-1:0]); end
        @(posedge clk); #1;
        send(8'd0, 8'd77, 8'd0, 3'd1);
        wait_out(lat, irh);
        n_vec++; if (lat !== W + 1) begin n_miss++; $display("FAIL mul_zero_latency: got %0d want %0d", lat, W + 1); end
        e = exp_q.pop_front();
        n_vec++; if ({err, z} !== e) begin n_miss++; $display("FAIL mul_zero_result: got err=%0b z=%0d want err=%0b z=%0d", err, z, e[2*W], e[2*W-1:0]); end
        @(posedge clk); #1;
    endtask

    task automatic test_sub_backpressure();
        int lat, irh;
        logic [2*W:0] e;
        out_ready = 1'b0;
        send(8'd3, 8'd5, 8'd0, 3'd4);
        wait_out(lat, irh);
        n_vec++; if (lat !== 1) begin n_miss++; $display("FAIL sub_latency: got %0d want 1", lat); end
        e = exp_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            n_vec++; if ({err, z} !== e || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_miss++; $display("FAIL sub_hold[%0d]: got z=%0d err=%0b ov=%0b ir=%0b want z=%0d err=%0b ov=1 ir=0", i, z, err, out_valid, in_ready, e[2*W-1:0], e[2*W]);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_miss++; $display("FAIL sub_release: got ov=%0b ir=%0b want 0/1", out_valid, in_ready); end
    endtask

    task automatic test_illegal();
        int lat, irh;
        logic [2*W:0] e;
        send(8'd1, 8'd2, 8'd3, 3'd7);
        wait_out(lat, irh);
        n_vec++; if (lat !== 1) begin n_miss++; $display("FAIL ill7_latency: got %0d want 1", lat); end
        e = exp_q.pop_front();
        n_vec++; if ({err, z} !== e) begin n_miss++; $display("FAIL ill7_result: got err=%0b z=%0d want err=%0b z=%0d", err, z, e[2*W], e[2*W-1:0]); end
        @(posedge clk); #1;
        send(8'd10, 8'd20, 8'd7, 3'd6);
        wait_out(lat, irh);
        n_vec++; if (lat !== exp_lat(3'd6)) begin n_miss++; $display("FAIL op6_latency: got %0d want %0d", lat, exp_lat(3'd6)); end
        e = exp_q.pop_front();
        n_vec++; if ({err, z} !== e) begin n_miss++; $display("FAIL op6_result: got err=%0b z=%0d want err=%0b z=%0d", err, z, e[2*W], e[2*W-1:0]); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_mul();
        int lat, irh, seen;
        logic [2*W:0] e;
        send(8'hAB, 8'hCD, 8'd0, 3'd5);
        wait_out(lat, irh);
        e = exp_q.pop_front();
        n_vec++; if ({err, z} !== e) begin n_miss++; $display("FAIL cat_pre_result: got err=%0b z=%0h want err=%0b z=%0h", err, z, e[2*W], e[2*W-1:0]); end
        @(posedge clk); #1;
        send(8'd200, 8'd201, 8'd0, 3'd1);
        repeat (3) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        void'(exp_q.pop_back());
        n_vec++; if (out_valid !== 1'b0 || z !== 16'd0 || in_ready !== 1'b1 || err !== 1'b0) begin
            n_miss++; $display("FAIL midreset_state: got ov=%0b z=%0d ir=%0b err=%0b want 0/0/1/0", out_valid, z, in_ready, err);
        end
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        n_vec++; if (seen !== 0) begin n_miss++; $display("FAIL midreset_no_valid: got %0d valid cycles want 0", seen); end
        send(8'h12, 8'h34, 8'd0, 3'd5);
        wait_out(lat, irh);
        e = exp_q.pop_front();
        n_vec++; if ({err, z} !== e) begin n_miss++; $display("FAIL cat_result: got err=%0b z=%0h want err=%0b z=%0h", err, z, e[2*W], e[2*W-1:0]); end
        @(posedge clk); #1;
    endtask

    task automatic test_operand_change();
        int lat, irh;
        logic [2*W:0] e;
        send(8'd13, 8'd11, 8'd0, 3'd1);
        for (int i = 0; i < 4; i++) begin
            a = W'($urandom); b = W'($urandom); s = 3'($urandom);
            @(posedge clk); #1;
        end
        wait_out(lat, irh);
        n_vec++; if (lat + 4 !== W + 1) begin n_miss++; $display("FAIL opchg_latency: got %0d want %0d", lat + 4, W + 1); end
        e = exp_q.pop_front();
        n_vec++; if ({err, z} !== e) begin n_miss++; $display("FAIL opchg_result: got err=%0b z=%0d want err=%0b z=%0d", err, z, e[2*W], e[2*W-1:0]); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int lat, irh;
        logic [2:0] ts;
        logic [2*W:0] e;
        for (int i = 0; i < 24; i++) begin
            ts = 3'($urandom_range(0, 7));
            send(W'($urandom), W'($urandom), W'($urandom), ts);
            wait_out(lat, irh);
            n_vec++; if (lat !== exp_lat(ts)) begin n_miss++; $display("FAIL b2b_latency[%0d]: op=%0d got %0d want %0d", i, ts, lat, exp_lat(ts)); end
            e = exp_q.pop_front();
            n_vec++; if ({err, z} !== e) begin n_miss++; $display("FAIL b2b_result[%0d]: op=%0d got err=%0b z=%0d want err=%0b z=%0d", i, ts, err, z, e[2*W], e[2*W-1:0]); end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_add3();
        test_mul();
        test_sub_backpressure();
        test_illegal();
        test_reset_mid_mul();
        test_operand_change();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
